// File: rtl/uart_cmd_parser.sv
// UART command parser: turns three-byte frames (column, row, character)
// received from a UART into single write requests for a text buffer.
// Frames addressing a cell outside the screen are discarded. A partial
// frame is also discarded if the gap between its bytes grows too long.
module uart_cmd_parser #(
    parameter int COLS    = 80,
    parameter int ROWS    = 30,
    parameter int TIMEOUT = 25000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [11:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        wr_valid_o,
    input  logic        wr_ready_i,
    output logic        err_o,
    output logic        busy_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        WAIT_COL,
        WAIT_ROW,
        WAIT_CHAR,
        EMIT
    } state_t;

    state_t        state;
    logic [7:0]    col_q;
    logic [7:0]    row_q;
    logic [TW-1:0] timer;
    logic          timed_out;
    logic          frame_ok;
    logic [11:0]   frame_addr;

    // The gap limit is reached on the TIMEOUT-th consecutive idle cycle
    assign timed_out = (timer == TW'(TIMEOUT - 1));

    // A frame is only written if it lands on a visible character cell
    assign frame_ok   = (int'(col_q) < COLS) && (int'(row_q) < ROWS);
    assign frame_addr = 12'(int'(row_q) * COLS + int'(col_q));

    assign busy_o = (state != WAIT_COL);

    // Frame decoder: collects the three bytes, then holds the write until accepted
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= WAIT_COL;
            col_q      <= '0;
            row_q      <= '0;
            timer      <= '0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            wr_valid_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                WAIT_COL: begin
                    timer <= '0;
                    if (rx_valid_i) begin
                        col_q <= rx_data_i;
                        state <= WAIT_ROW;
                    end
                end
                WAIT_ROW: begin
                    if (rx_valid_i) begin
                        row_q <= rx_data_i;
                        timer <= '0;
                        state <= WAIT_CHAR;
                    end else if (timed_out) begin
                        err_o <= 1'b1;
                        timer <= '0;
                        state <= WAIT_COL;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_CHAR: begin
                    if (rx_valid_i) begin
                        timer <= '0;
                        if (frame_ok) begin
                            wr_addr_o  <= frame_addr;
                            wr_data_o  <= rx_data_i;
                            wr_valid_o <= 1'b1;
                            state      <= EMIT;
                        end else begin
                            err_o <= 1'b1;
                            state <= WAIT_COL;
                        end
                    end else if (timed_out) begin
                        err_o <= 1'b1;
                        timer <= '0;
                        state <= WAIT_COL;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                EMIT: begin
                    timer <= '0;
                    if (rx_valid_i) begin
                        err_o <= 1'b1;
                    end
                    if (wr_ready_i) begin
                        wr_valid_o <= 1'b0;
                        state      <= WAIT_COL;
                    end
                end
                default: begin
                    state <= WAIT_COL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: table of single frames, hand-written
// sequences for stalls, dropped bytes, gap timeout and reset, and a
// randomized run checked against a frame-level reference model.
module tb_uart_cmd_parser;

    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int TIMEOUT = 25000;

    logic        clk_i;
    logic        rstn_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [11:0] wr_addr_o;
    logic [7:0]  wr_data_o;
    logic        wr_valid_o;
    logic        wr_ready_i;
    logic        err_o;
    logic        busy_o;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [7:0] col;
        logic [7:0] row;
        logic [7:0] ch;
        bit         exp_err;
        int         exp_addr;
    } vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    vec_t vecs[8];
    wr_t  exp_q[$];
    wr_t  exp_wr;
    bit   random_mode;
    int   err_seen;
    int   err_expected;

    uart_cmd_parser #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .wr_valid_o (wr_valid_o),
        .wr_ready_i (wr_ready_i),
        .err_o      (err_o),
        .busy_o     (busy_o)
    );

    // Free-running 100 MHz clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Compare one observed value with the value the bench expects
    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present one byte for exactly one rising edge; returns on the next falling edge
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk_i);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wr_valid"}, wr_valid_o, 0);
        checkOutput({tag, "_wr_addr"}, wr_addr_o, 0);
        checkOutput({tag, "_wr_data"}, wr_data_o, 0);
        checkOutput({tag, "_err"}, err_o, 0);
        checkOutput({tag, "_busy"}, busy_o, 0);
    endtask

    // Randomized phase: random back-pressure, and every accepted write is
    // matched against the model's queue of expected writes
    always @(negedge clk_i) begin
        if (random_mode) begin
            wr_ready_i = 1'($urandom_range(0, 1));
            if (err_o) err_seen++;
            if (wr_valid_o && wr_ready_i) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rand_unexpected_write", 1, 0);
                end else begin
                    exp_wr = exp_q.pop_front();
                    checkOutput("rand_addr", wr_addr_o, exp_wr.addr);
                    checkOutput("rand_data", wr_data_o, exp_wr.data);
                end
            end
        end
    end

    initial begin
        int err_at;
        bit saw_write;

        tests_run    = 0;
        tests_failed = 0;
        random_mode  = 1'b0;
        err_seen     = 0;
        err_expected = 0;
        rstn_i       = 1'b0;
        rx_data_i    = '0;
        rx_valid_i   = 1'b0;
        wr_ready_i   = 1'b1;

        vecs[0] = '{col: 8'd0,   row: 8'd0,   ch: 8'h41, exp_err: 1'b0, exp_addr: 0};
        vecs[1] = '{col: 8'd79,  row: 8'd29,  ch: 8'h5A, exp_err: 1'b0, exp_addr: 2399};
        vecs[2] = '{col: 8'd80,  row: 8'd0,   ch: 8'h41, exp_err: 1'b1, exp_addr: 0};
        vecs[3] = '{col: 8'd0,   row: 8'd30,  ch: 8'h41, exp_err: 1'b1, exp_addr: 0};
        vecs[4] = '{col: 8'd5,   row: 8'd2,   ch: 8'h42, exp_err: 1'b0, exp_addr: 165};
        vecs[5] = '{col: 8'd1,   row: 8'd1,   ch: 8'h43, exp_err: 1'b0, exp_addr: 81};
        vecs[6] = '{col: 8'd255, row: 8'd255, ch: 8'h7E, exp_err: 1'b1, exp_addr: 0};
        vecs[7] = '{col: 8'd79,  row: 8'd0,   ch: 8'h20, exp_err: 1'b0, exp_addr: 79};

        repeat (3) @(negedge clk_i);
        checkAllZero("reset");
        rstn_i = 1'b1;

        // Single frames with the buffer always ready
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].col);
            applyStimulus(vecs[i].row);
            applyStimulus(vecs[i].ch);
            if (vecs[i].exp_err) begin
                checkOutput($sformatf("vec%0d_err", i), err_o, 1);
                checkOutput($sformatf("vec%0d_no_write", i), wr_valid_o, 0);
                checkOutput($sformatf("vec%0d_busy", i), busy_o, 0);
            end else begin
                checkOutput($sformatf("vec%0d_valid", i), wr_valid_o, 1);
                checkOutput($sformatf("vec%0d_addr", i), wr_addr_o, vecs[i].exp_addr);
                checkOutput($sformatf("vec%0d_data", i), wr_data_o, vecs[i].ch);
                checkOutput($sformatf("vec%0d_err", i), err_o, 0);
            end
            @(negedge clk_i);
            checkOutput($sformatf("vec%0d_valid_after", i), wr_valid_o, 0);
            checkOutput($sformatf("vec%0d_busy_after", i), busy_o, 0);
            checkOutput($sformatf("vec%0d_err_after", i), err_o, 0);
        end

        // Stalled write: request and payload hold steady while not ready
        wr_ready_i = 1'b0;
        applyStimulus(8'd5);
        applyStimulus(8'd2);
        applyStimulus(8'h42);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("stall%0d_valid", i), wr_valid_o, 1);
            checkOutput($sformatf("stall%0d_addr", i), wr_addr_o, 165);
            checkOutput($sformatf("stall%0d_data", i), wr_data_o, 8'h42);
            @(negedge clk_i);
        end
        // A stray byte during the stall is dropped with an error
        applyStimulus(8'h99);
        checkOutput("drop_err", err_o, 1);
        checkOutput("drop_valid", wr_valid_o, 1);
        checkOutput("drop_addr", wr_addr_o, 165);
        checkOutput("drop_data", wr_data_o, 8'h42);
        wr_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("stall_done_valid", wr_valid_o, 0);
        checkOutput("stall_done_busy", busy_o, 0);
        checkOutput("stall_done_err", err_o, 0);
        checkOutput("stall_hold_addr", wr_addr_o, 165);
        checkOutput("stall_hold_data", wr_data_o, 8'h42);

        // Gap timeout after the column byte
        applyStimulus(8'd3);
        err_at = -1;
        for (int k = 1; k <= TIMEOUT + 10; k++) begin
            @(negedge clk_i);
            if (err_o) begin
                err_at = k;
                break;
            end
        end
        checkOutput("timeout_cycle", err_at, TIMEOUT);
        checkOutput("timeout_busy", busy_o, 0);
        applyStimulus(8'd1);
        applyStimulus(8'd1);
        applyStimulus(8'h43);
        checkOutput("after_timeout_valid", wr_valid_o, 1);
        checkOutput("after_timeout_addr", wr_addr_o, 81);
        checkOutput("after_timeout_data", wr_data_o, 8'h43);
        @(negedge clk_i);

        // A byte arriving on the very cycle the gap limit is reached wins
        applyStimulus(8'd3);
        err_at = 0;
        for (int k = 0; k < TIMEOUT - 2; k++) begin
            @(negedge clk_i);
            if (err_o) err_at = 1;
        end
        applyStimulus(8'd1);
        if (err_o) err_at = 1;
        checkOutput("priority_no_err", err_at, 0);
        checkOutput("priority_busy", busy_o, 1);
        applyStimulus(8'h43);
        checkOutput("priority_valid", wr_valid_o, 1);
        checkOutput("priority_addr", wr_addr_o, 83);
        @(negedge clk_i);

        // Reset after the row byte abandons the frame
        applyStimulus(8'd0);
        applyStimulus(8'd0);
        rstn_i = 1'b0;
        #1;
        checkAllZero("rst_midframe");
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        applyStimulus(8'd0);
        applyStimulus(8'd0);
        applyStimulus(8'h41);
        checkOutput("rst_frame_valid", wr_valid_o, 1);
        checkOutput("rst_frame_addr", wr_addr_o, 0);
        checkOutput("rst_frame_data", wr_data_o, 8'h41);
        @(negedge clk_i);

        // Reset while a write is pending discards it
        wr_ready_i = 1'b0;
        applyStimulus(8'd7);
        applyStimulus(8'd0);
        applyStimulus(8'h30);
        checkOutput("rst_emit_pending", wr_valid_o, 1);
        rstn_i = 1'b0;
        #1;
        checkAllZero("rst_emit");
        @(negedge clk_i);
        rstn_i     = 1'b1;
        wr_ready_i = 1'b1;
        saw_write  = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            if (wr_valid_o) saw_write = 1'b1;
        end
        checkOutput("rst_emit_no_write", saw_write, 0);
        applyStimulus(8'd0);
        applyStimulus(8'd0);
        applyStimulus(8'h41);
        checkOutput("rst_emit_next_addr", wr_addr_o, 0);
        checkOutput("rst_emit_next_data", wr_data_o, 8'h41);
        @(negedge clk_i);

        // Randomized frames against the reference model
        random_mode = 1'b1;
        for (int f = 0; f < 150; f++) begin
            logic [7:0] col;
            logic [7:0] row;
            logic [7:0] ch;
            int guard;
            guard = 0;
            while (busy_o && guard < 200) begin
                @(negedge clk_i);
                guard++;
            end
            if (busy_o) checkOutput("rand_idle_wait", busy_o, 0);
            col = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, COLS - 1)) : 8'($urandom_range(0, 255));
            row = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, ROWS - 1)) : 8'($urandom_range(0, 255));
            ch  = 8'($urandom_range(0, 255));
            if (int'(col) < COLS && int'(row) < ROWS)
                exp_q.push_back('{addr: 12'(int'(row) * COLS + int'(col)), data: ch});
            else
                err_expected++;
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            applyStimulus(col);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            applyStimulus(row);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            applyStimulus(ch);
        end
        begin
            int guard;
            guard = 0;
            while ((busy_o || exp_q.size() != 0) && guard < 500) begin
                @(negedge clk_i);
                guard++;
            end
        end
        repeat (2) @(negedge clk_i);
        random_mode = 1'b0;
        wr_ready_i  = 1'b1;
        checkOutput("rand_pending_writes", exp_q.size(), 0);
        checkOutput("rand_err_count", err_seen, err_expected);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter COLS, default 80, text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, text rows per screen.
REQ-003 SHALL have parameter TIMEOUT, default 25000, idle clk cycles allowed between bytes of one frame (1 ms at 25 MHz).
REQ-004 SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx_data_i  input  8  received UART byte.
REQ-007 SHALL have port rx_valid_i  input  1  one-cycle strobe; rx_data_i is valid while it is high.
REQ-008 SHALL have port wr_addr_o  output  12  text-buffer address, row*COLS+col.
REQ-009 SHALL have port wr_data_o  output  8  character code to store.
REQ-010 SHALL have port wr_valid_o  output  1  write request to the text buffer.
REQ-011 SHALL have port wr_ready_i  input  1  text buffer accepts the write when high together with wr_valid_o.
REQ-012 SHALL have port err_o  output  1  one-cycle pulse on a discarded frame or dropped byte.
REQ-013 SHALL have port busy_o  output  1  high whenever state is not WAIT_COL.

Function
REQ-014 SHALL decode frames of three bytes in order: column, row, character.
REQ-015 SHALL implement states WAIT_COL, WAIT_ROW, WAIT_CHAR, EMIT.
REQ-016 SHALL, in WAIT_COL on rx_valid_i, latch the byte as column and go to WAIT_ROW.
REQ-017 SHALL, in WAIT_ROW on rx_valid_i, latch the byte as row and go to WAIT_CHAR.
REQ-018 SHALL, in WAIT_CHAR on rx_valid_i with column<COLS and row<ROWS, register address and character and go to EMIT.
REQ-019 SHALL, in WAIT_CHAR on rx_valid_i with column>=COLS or row>=ROWS, pulse err_o for one cycle, issue no write, and return to WAIT_COL.
REQ-020 SHALL assert wr_valid_o in the cycle after the character byte is accepted (latency 1).
REQ-021 SHALL hold wr_valid_o, wr_addr_o and wr_data_o stable while in EMIT until wr_ready_i is high.
REQ-022 SHALL, on the edge where wr_valid_o and wr_ready_i are both high, deassert wr_valid_o and return to WAIT_COL.
REQ-023 SHALL compute the address as row*COLS+col with no truncation within 12 bits; maximum 2399 with default parameters.
REQ-024 SHALL drop any rx_valid_i byte arriving in EMIT, pulse err_o, and keep the pending write unchanged.
REQ-025 SHALL run a timeout counter in WAIT_ROW and WAIT_CHAR; it clears on every accepted byte.
REQ-026 SHALL, when the counter reaches TIMEOUT without rx_valid_i, pulse err_o and return to WAIT_COL, discarding the partial frame.
REQ-027 SHALL give rx_valid_i priority over timeout in the same cycle: the byte is accepted and no error is raised.
REQ-028 SHALL hold the timeout counter at 0 in WAIT_COL and EMIT.
REQ-029 SHALL, when wr_ready_i is already high in the first EMIT cycle, complete the write in that single cycle.
REQ-030 SHALL hold wr_addr_o and wr_data_o at their last values when wr_valid_o is low.

Reset
REQ-031 SHALL, while rstn_i is low, force state WAIT_COL, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, err_o=0, busy_o=0, timeout counter=0.
REQ-032 SHALL, on reset mid-frame or in EMIT, abandon the frame with no write after reset is released.
REQ-033 SHALL accept a new frame starting with the first rx_valid_i after rstn_i goes high.

Verification
REQ-034 SHALL cover: bytes 0x00,0x00,0x41 with wr_ready_i=1 -> one wr_valid_o pulse, addr 0, data 0x41, err_o never high.
REQ-035 SHALL cover: bytes 79,29,0x5A -> addr 2399, data 0x5A; bytes 80,0,0x41 -> err_o pulse, no write, busy_o low next cycle.
REQ-036 SHALL cover: frame 5,2,0x42 with wr_ready_i=0 for 10 cycles -> wr_valid_o high and addr 165, data 0x42 stable for 10 cycles; write completes on the first ready cycle.
REQ-037 SHALL cover: byte 3 then 25000 idle cycles -> err_o pulse, back to WAIT_COL; next frame 1,1,0x43 -> addr 81.
REQ-038 SHALL cover: extra byte during EMIT with wr_ready_i=0 -> err_o pulse, pending addr/data unchanged.
REQ-039 SHALL cover: rstn_i low after the row byte -> all outputs 0; frame 0,0,0x41 after release -> addr 0, data 0x41.
